board_vram_write_arbiter: RTL and testbench
===========================================

# board_vram_write_arbiter

Write-side controller for the 14x14x6-bit board VRAM, whose read port is owned by the VGA drawing path. It shares the single VRAM write port between two requesters (game/move logic and CPU) with round-robin arbitration, converts board (x,y) coordinates to linear addresses, and runs a built-in clear sequence that sweeps the whole board. All write-port outputs are registered. The block sits between the game logic and the VRAM `wraddress`/`data`/`wren` pins.

## Interface
- BOARD_W, 14, board width in cells; BOARD_W*BOARD_H ≤ 256
- BOARD_H, 14, board height in cells
- DATA_W, 6, cell data width
- CLEAR_VALUE, 0, value written to every cell by the clear sequence
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req0, req1  in  1  write request; held until the matching ack
- x0, y0, x1, y1  in  4  cell coordinates; stable while req is high
- d0, d1  in  DATA_W  write data; stable while req is high
- ack0, ack1  out  1  one-cycle completion pulse
- err0, err1  out  1  one-cycle pulse with ack: coordinate out of range, nothing written
- clear_start  in  1  pulse that starts the board clear
- busy  out  1  high while the clear sequence is running
- clear_done  out  1  one-cycle pulse after the last clear write
- vram_wren  out  1  VRAM write enable
- vram_wraddress  out  8  VRAM write address
- vram_data  out  DATA_W  VRAM write data

## Operation
- Reset value of every output is 0. The round-robin pointer resets to "req0 preferred". The FSM resets to IDLE and the clear counter to 0.
- FSM states:
  - IDLE to CLEAR on clear_start (build-dependent, see Configuration).
  - CLEAR to IDLE after address BOARD_W*BOARD_H-1 has been written.
- Request eligibility: reqN is eligible when reqN=1 and ackN=0 in the same cycle. The ack cycle is masked so a held request is never written twice.
- Arbitration happens in IDLE only, with one grant per cycle:
  - Exactly one requester eligible: it is granted.
  - Both eligible: the requester not granted last wins. The pointer updates on every grant, including error grants.
- Granted request, coordinates in range (x < BOARD_W, y < BOARD_H):
  - next cycle: vram_wren=1, vram_wraddress=y*BOARD_W+x (8-bit, no truncation possible), vram_data=dN, ackN=1.
- Granted request, coordinates out of range:
  - next cycle: ackN=1, errN=1, vram_wren=0.
- CLEAR state:
  - Each cycle: vram_wren=1, vram_wraddress=counter, vram_data=CLEAR_VALUE; counter increments by 1 per cycle.
  - No grants are made; requests stall with ack=0 and are serviced after the clear.
  - busy=1 for all BOARD_W*BOARD_H write cycles.
- clear_start while busy=1 is ignored.
- clear_start in the same cycle as an eligible request: the clear wins and the request waits.
- Reset mid-clear: outputs return to 0 immediately, FSM goes to IDLE, the clear is not resumed, and the partially cleared board is left as-is.

## Timing
- Request to write: 1 cycle. req sampled at edge N; vram_wren, ack and err are valid in cycle N+1.
- A requester deasserts req or presents the next request in cycle N+2 or later.
- Throughput:
  - single requester holding req continuously: one write every 2 cycles.
  - two requesters: one write per cycle, alternating.
- Clear sequence: clear_start sampled at edge N. Writes occupy cycles N+1 … N+196. busy is high over the same cycles. clear_done=1 in cycle N+197, with busy=0 and the FSM back in IDLE.
- Requests may be granted from edge N+197 onward.
- vram_wren, vram_wraddress and vram_data change only on clk edges (registered, glitch-free).

## Configuration
- BOARD_VRAM_CLEAR_EN
  - Defined: CLEAR state, counter and clear_done logic are compiled in and behave as above.
  - Not defined: the clear logic is removed. clear_start is ignored, busy and clear_done are tied to 0, and the block is a pure two-port round-robin write arbiter.

## Test plan
- Reset release, then req0=1 with x0=3, y0=2, d0=6'h15 held until ack → one cycle later vram_wren=1, vram_wraddress=31, vram_data=6'h15, ack0=1; exactly one write occurs.
- req0 and req1 held high continuously with distinct data → writes alternate 0,1,0,1 on consecutive cycles; the first grant after reset goes to req0.
- req1=1 with x1=14, y1=0 → ack1=1 and err1=1 in the same cycle, vram_wren stays 0; the next simultaneous request grants req0.
- clear_start pulse with BOARD_VRAM_CLEAR_EN defined, req0 held during the clear → 196 writes, addresses 0..195, data 0, busy high throughout; clear_done at +197; req0 acked after clear_done; a clear_start pulse during the sweep has no effect.
- rst_n asserted at clear address 100 → all outputs are 0 asynchronously; after release busy=0 and a new request is serviced normally.
- BOARD_VRAM_CLEAR_EN undefined, clear_start pulsed → no vram_wren, busy and clear_done stay 0, requests proceed unaffected.

Source files
------------

// File: rtl/board_vram_write_arbiter.sv
// Round-robin arbiter for the board VRAM write port, with (x,y) to address conversion.
// Defining BOARD_VRAM_CLEAR_EN compiles in the whole-board clear sweep.
module board_vram_write_arbiter #(
  parameter int BOARD_W     = 14,
  parameter int BOARD_H     = 14,
  parameter int DATA_W      = 6,
  parameter int CLEAR_VALUE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        x0,
  input  logic [3:0]        y0,
  input  logic [3:0]        x1,
  input  logic [3:0]        y1,
  input  logic [DATA_W-1:0] d0,
  input  logic [DATA_W-1:0] d1,
  output logic              ack0,
  output logic              ack1,
  output logic              err0,
  output logic              err1,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done,
  output logic              vram_wren,
  output logic [7:0]        vram_wraddress,
  output logic [DATA_W-1:0] vram_data
);

  localparam logic [8:0] CELLS = 9'(BOARD_W * BOARD_H);
  localparam logic [8:0] W9    = 9'(BOARD_W);
  localparam logic [8:0] H9    = 9'(BOARD_H);
  localparam logic [7:0] W8    = 8'(BOARD_W);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t            state_reg;
  logic              pref_reg;
  logic [1:0]        ack_reg;
  logic [1:0]        err_reg;

  logic [1:0]        req_v;
  logic [3:0]        x_v    [2];
  logic [3:0]        y_v    [2];
  logic [DATA_W-1:0] d_v    [2];
  logic [7:0]        addr_v [2];
  logic [1:0]        elig;
  logic [1:0]        in_range;
  logic              grant_valid;
  logic              grant_idx;

  assign req_v  = {req1, req0};
  assign x_v[0] = x0;
  assign x_v[1] = x1;
  assign y_v[0] = y0;
  assign y_v[1] = y1;
  assign d_v[0] = d0;
  assign d_v[1] = d1;

  // A requester is masked during its ack cycle so a held request is not written twice.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_req
      assign elig[gi]     = req_v[gi] & ~ack_reg[gi];
      assign in_range[gi] = ({5'd0, x_v[gi]} < W9) && ({5'd0, y_v[gi]} < H9);
      assign addr_v[gi]   = 8'(y_v[gi]) * W8 + 8'(x_v[gi]);
    end
  endgenerate

  assign grant_valid = |elig;
  assign grant_idx   = (&elig) ? pref_reg : elig[1];

  assign ack0 = ack_reg[0];
  assign ack1 = ack_reg[1];
  assign err0 = err_reg[0];
  assign err1 = err_reg[1];

`ifdef BOARD_VRAM_CLEAR_EN
  logic [8:0] clr_cnt_reg;
  logic       busy_reg;
  logic       done_reg;

  assign busy       = busy_reg;
  assign clear_done = done_reg;
`else
  logic clear_start_unused;

  assign clear_start_unused = clear_start;
  assign busy               = 1'b0;
  assign clear_done         = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      pref_reg       <= 1'b0;
      ack_reg        <= '0;
      err_reg        <= '0;
      vram_wren      <= 1'b0;
      vram_wraddress <= '0;
      vram_data      <= '0;
`ifdef BOARD_VRAM_CLEAR_EN
      clr_cnt_reg    <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
`endif
    end else begin
      ack_reg   <= '0;
      err_reg   <= '0;
      vram_wren <= 1'b0;
`ifdef BOARD_VRAM_CLEAR_EN
      done_reg  <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
`ifdef BOARD_VRAM_CLEAR_EN
          // The clear takes priority; cell 0 is written on the starting edge itself.
          if (clear_start) begin
            state_reg      <= CLEAR;
            busy_reg       <= 1'b1;
            clr_cnt_reg    <= 9'd1;
            vram_wren      <= 1'b1;
            vram_wraddress <= '0;
            vram_data      <= DATA_W'(CLEAR_VALUE);
          end else
`endif
          if (grant_valid) begin
            pref_reg           <= ~grant_idx;
            ack_reg[grant_idx] <= 1'b1;
            if (in_range[grant_idx]) begin
              vram_wren      <= 1'b1;
              vram_wraddress <= addr_v[grant_idx];
              vram_data      <= d_v[grant_idx];
            end else begin
              err_reg[grant_idx] <= 1'b1;
            end
          end
        end
`ifdef BOARD_VRAM_CLEAR_EN
        CLEAR: begin
          if (clr_cnt_reg == CELLS) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b1;
            clr_cnt_reg <= '0;
          end else begin
            vram_wren      <= 1'b1;
            vram_wraddress <= clr_cnt_reg[7:0];
            vram_data      <= DATA_W'(CLEAR_VALUE);
            clr_cnt_reg    <= clr_cnt_reg + 9'd1;
          end
        end
`endif
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_vram_write_arbiter.sv
// Bench for board_vram_write_arbiter: directed cases plus random traffic against
// a cycle-schedule reference model (clear cases only when BOARD_VRAM_CLEAR_EN is set).
module tb_board_vram_write_arbiter;

  localparam int W     = 14;
  localparam int H     = 14;
  localparam int DW    = 6;
  localparam int CV    = 0;
  localparam int CELLS = W * H;
`ifdef BOARD_VRAM_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1;
  logic [3:0]    x0, y0, x1, y1;
  logic [DW-1:0] d0, d1;
  logic          ack0, ack1, err0, err1;
  logic          clear_start;
  logic          busy, clear_done;
  logic          vram_wren;
  logic [7:0]    vram_wraddress;
  logic [DW-1:0] vram_data;

  always #5 clk = ~clk;

  board_vram_write_arbiter #(
    .BOARD_W(W), .BOARD_H(H), .DATA_W(DW), .CLEAR_VALUE(CV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1),
    .d0(d0), .d1(d1),
    .ack0(ack0), .ack1(ack1), .err0(err0), .err1(err1),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .vram_wren(vram_wren), .vram_wraddress(vram_wraddress), .vram_data(vram_data)
  );

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: expected outputs for the cycle after each edge
  logic          e_wren, e_busy, e_done;
  logic [1:0]    e_ack, e_err;
  logic [7:0]    e_addr;
  logic [DW-1:0] e_data;
  int            last_gnt;
  int            ecount;
  int            clr_at;

  task automatic model_reset();
    e_wren = 0; e_busy = 0; e_done = 0; e_ack = 0; e_err = 0;
    e_addr = 0; e_data = 0;
    last_gnt = 1;
    ecount = 0;
    clr_at = -1000000;
  endtask

  task automatic model_edge();
    int k, win;
    int xs[2], ys[2], ds[2];
    logic [1:0] el;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ecount++;
    k = ecount - clr_at;
    el = {req1, req0} & ~e_ack;
    e_wren = 0; e_ack = 0; e_err = 0; e_done = 0;
    if (k >= 1 && k <= CELLS) begin
      if (k < CELLS) begin
        e_wren = 1; e_addr = 8'(k); e_data = DW'(CV); e_busy = 1;
      end else begin
        e_busy = 0; e_done = 1;
      end
    end else if (CLR_EN && clear_start) begin
      clr_at = ecount;
      e_wren = 1; e_addr = 0; e_data = DW'(CV); e_busy = 1;
    end else if (el != 0) begin
      win = (el == 2'b11) ? 1 - last_gnt : (el[1] ? 1 : 0);
      last_gnt = win;
      xs[0] = int'(x0); xs[1] = int'(x1);
      ys[0] = int'(y0); ys[1] = int'(y1);
      ds[0] = int'(d0); ds[1] = int'(d1);
      e_ack[win] = 1;
      if (xs[win] < W && ys[win] < H) begin
        e_wren = 1; e_addr = 8'(ys[win] * W + xs[win]); e_data = DW'(ds[win]);
      end else begin
        e_err[win] = 1;
      end
    end
  endtask

  task automatic compare();
    check_val("wren", vram_wren, e_wren);
    check_val("addr", vram_wraddress, e_addr);
    check_val("data", vram_data, e_data);
    check_val("ack0", ack0, e_ack[0]);
    check_val("ack1", ack1, e_ack[1]);
    check_val("err0", err0, e_err[0]);
    check_val("err1", err1, e_err[1]);
    check_val("busy", busy, e_busy);
    check_val("clear_done", clear_done, e_done);
  endtask

  // Inputs are set at the negedge; model sees exactly what the DUT samples.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare();
    if (ack0) $display("txn req0 err=%0d wren=%0d addr=%0d data=%0h", err0, vram_wren, vram_wraddress, vram_data);
    if (ack1) $display("txn req1 err=%0d wren=%0d addr=%0d data=%0h", err1, vram_wren, vram_wraddress, vram_data);
    if (clear_done) $display("txn clear done");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) cycle();
    rst_n = 1'b1;
  endtask

  // Random requesters: hold until ack, change no earlier than the cycle after ack
  logic [1:0] ack_seen_prev;

  task automatic drive_rand();
    logic can0, can1;
    can0 = !req0 || ack_seen_prev[0];
    can1 = !req1 || ack_seen_prev[1];
    ack_seen_prev = {ack1, ack0};
    if (can0) begin
      req0 = ($urandom_range(0, 2) != 0);
      x0 = 4'($urandom_range(0, 15)); y0 = 4'($urandom_range(0, 15)); d0 = DW'($urandom);
    end
    if (can1) begin
      req1 = ($urandom_range(0, 2) != 0);
      x1 = 4'($urandom_range(0, 15)); y1 = 4'($urandom_range(0, 15)); d1 = DW'($urandom);
    end
    clear_start = ($urandom_range(0, 199) == 0);
  endtask

  int writes, lat, got;

  initial begin
    rst_n = 0; req0 = 0; req1 = 0; clear_start = 0;
    x0 = 0; y0 = 0; x1 = 0; y1 = 0; d0 = 0; d1 = 0;
    ack_seen_prev = 0;
    model_reset();
    do_reset();
    check_val("reset_outs", {ack0, ack1, err0, err1, busy, clear_done, vram_wren, vram_wraddress, vram_data}, 0);

    // single write at (3,2)
    req0 = 1; x0 = 3; y0 = 2; d0 = 6'h15;
    got = 0; writes = 0; lat = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      cycle(); lat++;
      if (vram_wren) writes++;
      if (ack0) got = 1;
    end
    check_val("t1_acked", got, 1);
    check_val("t1_latency", lat, 1);
    check_val("t1_addr", vram_wraddress, 31);
    check_val("t1_data", vram_data, 6'h15);
    cycle();
    if (vram_wren) writes++;
    req0 = 0;
    repeat (3) begin
      cycle();
      if (vram_wren) writes++;
    end
    check_val("t1_writes", writes, 1);

    // out-of-range x on req1, then the pointer favours req0
    req1 = 1; x1 = 14; y1 = 0; d1 = 6'h2B;
    got = 0;
    for (int i = 0; i < 10 && got == 0; i++) begin
      cycle();
      if (ack1) got = 1;
    end
    check_val("t3_acked", got, 1);
    check_val("t3_err1", err1, 1);
    check_val("t3_wren", vram_wren, 0);
    cycle();
    req0 = 1; x0 = 0; y0 = 0; d0 = 6'h01;
    req1 = 1; x1 = 13; y1 = 13; d1 = 6'h02;
    cycle();
    check_val("t3_rr_req0", ack0, 1);
    cycle();
    req1 = 0;
    cycle();
    req0 = 0;
    cycle();

    // both held after reset: 0,1,0,1 ...
    do_reset();
    req0 = 1; x0 = 1; y0 = 1; d0 = 6'h0A;
    req1 = 1; x1 = 5; y1 = 7; d1 = 6'h35;
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_val("t2_alt_ack0", ack0, (i % 2 == 0));
      check_val("t2_alt_ack1", ack1, (i % 2 == 1));
      check_val("t2_alt_addr", vram_wraddress, (i % 2 == 0) ? 15 : 103);
    end
    req0 = 0;
    cycle();
    req1 = 0;
    cycle();

`ifdef BOARD_VRAM_CLEAR_EN
    begin
      int j, busy_cnt, done_at, ack_at, addr_bad;
      clear_start = 1;
      req0 = 1; x0 = 4; y0 = 4; d0 = 6'h2A;
      cycle();
      clear_start = 0;
      j = 1; writes = 0; busy_cnt = 0; done_at = 0; ack_at = 0; addr_bad = 0;
      while (j <= 260) begin
        if (busy) begin
          busy_cnt++;
          if (vram_wren) begin
            if (int'(vram_wraddress) != writes || vram_data != DW'(CV)) addr_bad++;
            writes++;
          end
        end
        if (clear_done && done_at == 0) done_at = j;
        if (ack0 && ack_at == 0) ack_at = j;
        if (ack_at != 0) break;
        clear_start = (j == 60);
        cycle();
        j++;
      end
      clear_start = 0;
      check_val("clr_writes", writes, CELLS);
      check_val("clr_busy_cycles", busy_cnt, CELLS);
      check_val("clr_addr_seq_bad", addr_bad, 0);
      check_val("clr_done_at", done_at, CELLS + 1);
      check_val("clr_req_ack_at", ack_at, CELLS + 2);
      cycle();
      req0 = 0;
      cycle();

      // asynchronous reset in the middle of a sweep
      clear_start = 1;
      cycle();
      clear_start = 0;
      got = 0;
      for (int i = 0; i < 300 && got == 0; i++) begin
        if (vram_wren && vram_wraddress == 8'd100) got = 1;
        else cycle();
      end
      check_val("rst_hit100", got, 1);
      rst_n = 0;
      #1;
      check_val("rst_async_outs", {ack0, ack1, err0, err1, busy, clear_done, vram_wren, vram_wraddress, vram_data}, 0);
      cycle();
      rst_n = 1;
      cycle();
      check_val("rst_busy_after", busy, 0);
      req1 = 1; x1 = 2; y1 = 3; d1 = 6'h07;
      cycle();
      check_val("rst_req_ack1", ack1, 1);
      check_val("rst_req_addr", vram_wraddress, 44);
      cycle();
      req1 = 0;
      cycle();
    end
`else
    begin
      int stray;
      clear_start = 1;
      req0 = 1; x0 = 0; y0 = 13; d0 = 6'h11;
      cycle();
      clear_start = 0;
      check_val("noclr_ack0", ack0, 1);
      check_val("noclr_addr", vram_wraddress, 182);
      check_val("noclr_busy", busy, 0);
      cycle();
      req0 = 0;
      stray = 0;
      for (int i = 0; i < 6; i++) begin
        clear_start = (i % 2 == 0);
        cycle();
        if (vram_wren || busy || clear_done) stray++;
      end
      clear_start = 0;
      check_val("noclr_stray", stray, 0);
    end
`endif

    // random traffic with one reset part-way through
    ack_seen_prev = 0;
    for (int c = 0; c < 1500; c++) begin
      if (c == 800) rst_n = 0;
      if (c == 802) rst_n = 1;
      drive_rand();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
